// File: rtl/ram.sv
// ram: simple dual-port RAM (DEPTH x DATA_W) that is write-first on a same-address collision.
// 1-cycle registered read, no backpressure; define RAM_INIT_EN to preload the padded SHA-1 "abc" block.
module ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic [ADDR_W-1:0] raddr,
  input  logic [ADDR_W-1:0] waddr,
  input  logic              we,
  output logic [DATA_W-1:0] dout
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

`ifdef RAM_INIT_EN
  // Declaration-time image: word 0 = "abc" followed by the pad bit, word 15 = message length of 24 bits.
  logic [DATA_W-1:0] mem [DEPTH] = '{
    0:       DATA_W'(32'h61626380),
    15:      DATA_W'(32'h00000018),
    default: '0
  };
`else
  logic [DATA_W-1:0] mem [DEPTH];
`endif

  logic w_ok;
  logic r_ok;
  logic bypass;

  assign w_ok   = we && ({1'b0, waddr} < DEPTH_L);
  assign r_ok   = {1'b0, raddr} < DEPTH_L;
  assign bypass = w_ok && (waddr == raddr);

  always_ff @(posedge clk) begin
    if (w_ok) begin
      mem[waddr] <= din;
    end
  end

  // Reset clears only the output register; the array keeps its contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
    end else if (bypass) begin
      dout <= din;
    end else if (r_ok) begin
      dout <= mem[raddr];
    end else begin
      dout <= '0;
    end
  end

endmodule

// File: tb/tb_ram.sv
// Bench for ram: directed scenarios plus a randomized run against an array-based reference model.
module tb_ram;

  logic        clk;
  logic        rst_n;
  logic [31:0] din;
  logic [6:0]  raddr;
  logic [6:0]  waddr;
  logic        we;
  logic [31:0] dout;

  int tests;
  int fails;

  logic [31:0] model [128];
  logic        known [128];

  ram dut (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (din),
    .raddr (raddr),
    .waddr (waddr),
    .we    (we),
    .dout  (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_write(input logic [6:0] a, input logic [31:0] d);
    model[a] = d;
    known[a] = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    we    = 1'b0;
    raddr = '0;
    waddr = '0;
    din   = '0;
    #3;
    tests++;
    if (dout !== 32'h0) begin
      fails++;
      $display("FAIL reset_async dout=%h expected=%h", dout, 32'h0);
    end
`ifndef RAM_INIT_EN
    we    = 1'b1;
    waddr = 7'd0;
    din   = 32'h61626380;
    model_write(7'd0, 32'h61626380);
`endif
    tick();
    we = 1'b0;
    tick();
    tests++;
    if (dout !== 32'h0) begin
      fails++;
      $display("FAIL reset_held dout=%h expected=%h", dout, 32'h0);
    end
    rst_n = 1'b1;
    tick();
    tests++;
    if (dout !== 32'h61626380) begin
      fails++;
      $display("FAIL reset_first_read dout=%h expected=%h", dout, 32'h61626380);
    end
  endtask

  task automatic test_preload();
    logic [31:0] exp;
    for (int i = 0; i < 16; i++) begin
      raddr = 7'(i);
      tick();
      exp = (i == 0) ? 32'h61626380 : (i == 15) ? 32'h00000018 : 32'h0;
      tests++;
      if (dout !== exp) begin
        fails++;
        $display("FAIL preload_addr%0d dout=%h expected=%h", i, dout, exp);
      end
    end
  endtask

  task automatic test_write_read();
    we = 1'b1;
    waddr = 7'd6;
    din = 32'hA5A5A5A5;
    model_write(7'd6, din);
    tick();
    waddr = 7'd5;
    din = 32'hDEADBEEF;
    model_write(7'd5, din);
    tick();
    we = 1'b0;
    raddr = 7'd5;
    tick();
    tests++;
    if (dout !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL write_read_addr5 dout=%h expected=%h", dout, 32'hDEADBEEF);
    end
    raddr = 7'd6;
    tick();
    tests++;
    if (dout !== 32'hA5A5A5A5) begin
      fails++;
      $display("FAIL write_read_addr6_unchanged dout=%h expected=%h", dout, 32'hA5A5A5A5);
    end
  endtask

  task automatic test_read_during_write();
    we = 1'b1;
    waddr = 7'd20;
    raddr = 7'd20;
    din = 32'h12345678;
    model_write(7'd20, din);
    tick();
    tests++;
    if (dout !== 32'h12345678) begin
      fails++;
      $display("FAIL rdw_same_addr dout=%h expected=%h", dout, 32'h12345678);
    end
    waddr = 7'd21;
    raddr = 7'd5;
    din = 32'h0BADF00D;
    model_write(7'd21, din);
    tick();
    tests++;
    if (dout !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL rdw_diff_addr dout=%h expected=%h", dout, 32'hDEADBEEF);
    end
    we = 1'b0;
    raddr = 7'd21;
    tick();
    tests++;
    if (dout !== 32'h0BADF00D) begin
      fails++;
      $display("FAIL rdw_diff_addr_written dout=%h expected=%h", dout, 32'h0BADF00D);
    end
  endtask

  task automatic test_async_reset();
    raddr = 7'd5;
    tick();
    tests++;
    if (dout !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL async_pre dout=%h expected=%h", dout, 32'hDEADBEEF);
    end
    #1;
    rst_n = 1'b0;
    #1;
    tests++;
    if (dout !== 32'h0) begin
      fails++;
      $display("FAIL async_clear dout=%h expected=%h", dout, 32'h0);
    end
    #1;
    rst_n = 1'b1;
    tick();
    tests++;
    if (dout !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL async_retained dout=%h expected=%h", dout, 32'hDEADBEEF);
    end
  endtask

  task automatic test_full_range();
    we = 1'b1;
    for (int k = 0; k < 128; k++) begin
      waddr = 7'(k);
      din = 32'(k) * 32'h01010101;
      model_write(waddr, din);
      tick();
    end
    we = 1'b0;
    for (int k = 0; k < 128; k++) begin
      raddr = 7'(k);
      tick();
      tests++;
      if (dout !== 32'(k) * 32'h01010101) begin
        fails++;
        $display("FAIL full_range_addr%0d dout=%h expected=%h", k, dout, 32'(k) * 32'h01010101);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] exp;
    for (int n = 0; n < 400; n++) begin
      we    = 1'($urandom_range(0, 1));
      raddr = 7'($urandom_range(0, 127));
      waddr = ($urandom_range(0, 3) == 0) ? raddr : 7'($urandom_range(0, 127));
      din   = $urandom;
      exp   = (we && waddr == raddr) ? din : model[raddr];
      if (we) model_write(waddr, din);
      tick();
      if (known[raddr]) begin
        tests++;
        if (dout !== exp) begin
          fails++;
          $display("FAIL random_cycle%0d addr=%0d dout=%h expected=%h", n, raddr, dout, exp);
        end
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    for (int i = 0; i < 128; i++) begin
      model[i] = '0;
      known[i] = 1'b0;
    end
`ifdef RAM_INIT_EN
    for (int i = 0; i < 128; i++) known[i] = 1'b1;
    model[0]  = 32'h61626380;
    model[15] = 32'h00000018;
`endif
    test_reset();
`ifdef RAM_INIT_EN
    test_preload();
`endif
    test_write_read();
    test_read_during_write();
    test_async_reset();
    test_full_range();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog timeout tests=%0d expected completion", tests);
    $fatal(1, "watchdog");
  end

endmodule
